// File: rtl/seg_pkg.sv
// Shared constants, digit-index type and BCD-to-7-segment decoder for the display mux.
package seg_pkg;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  typedef logic [1:0] digit_idx_t;

  // Active-low cathodes; bit0 = a .. bit6 = g, bit7 = dp (always off).
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg_display_mux_if.sv
// Digit-word load handshake between the producer (master) and the display mux (slave).
interface seg_display_mux_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (output load_valid, load_data, input load_ready);
  modport slave  (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seg_refresh_tick.sv
// Free-running divider: o_tick is high for the one cycle in which the count wraps.
module seg_refresh_tick #(
  parameter int DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous digit loads and
// leading-zero blanking. Define SEG_BLINK_EN to add the doneCounting blink feature.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLINK_HALF    = 25000000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic             Clk100M,
  input  logic             Rst_n,
  seg_display_mux_if.slave ld,
  input  logic             doneCounting,
  output logic [7:0]       seg,
  output logic [3:0]       an
);
  logic        w_tick, w_frame, w_xfer, w_off, w_blank;
  digit_idx_t  r_idx, w_idx_nxt;
  logic [15:0] r_active, r_shadow, w_active_nxt;
  logic        r_pending;
  logic [3:0]  w_dig, w_an_nxt, r_an;
  logic [7:0]  w_seg_nxt, r_seg;

  seg_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .i_clk   (Clk100M),
    .i_rst_n (Rst_n),
    .o_tick  (w_tick)
  );

  assign w_frame       = w_tick && (r_idx == 2'd3);
  assign ld.load_ready = !r_pending;
  assign w_xfer        = ld.load_valid && !r_pending;
  assign w_idx_nxt     = w_tick ? r_idx + 2'd1 : r_idx;
  // The shadow word only reaches the scan at a frame boundary, never mid-frame.
  assign w_active_nxt  = (w_frame && r_pending) ? r_shadow : r_active;

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_idx     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_active <= w_active_nxt;
      if (w_xfer) begin
        r_shadow  <= ld.load_data;
        r_pending <= 1'b1;
      end else if (w_frame) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int LW = $clog2(BLINK_TOGGLES + 1);

  logic [HW-1:0] r_blink_tmr, w_tmr_nxt;
  logic [LW-1:0] r_blink_left, w_left_nxt;
  logic          r_blink_ph, w_ph_nxt;

  // A new pulse always restarts the sequence from an even (lit) half-period.
  always_comb begin
    w_tmr_nxt  = r_blink_tmr;
    w_left_nxt = r_blink_left;
    w_ph_nxt   = r_blink_ph;
    if (doneCounting) begin
      w_tmr_nxt  = '0;
      w_left_nxt = LW'(BLINK_TOGGLES);
      w_ph_nxt   = 1'b0;
    end else if (r_blink_left != '0) begin
      if (r_blink_tmr == HW'(BLINK_HALF - 1)) begin
        w_tmr_nxt  = '0;
        w_left_nxt = r_blink_left - LW'(1);
        w_ph_nxt   = ~r_blink_ph;
      end else begin
        w_tmr_nxt  = r_blink_tmr + HW'(1);
      end
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_blink_tmr  <= '0;
      r_blink_left <= '0;
      r_blink_ph   <= 1'b0;
    end else begin
      r_blink_tmr  <= w_tmr_nxt;
      r_blink_left <= w_left_nxt;
      r_blink_ph   <= w_ph_nxt;
    end
  end

  assign w_off = (w_left_nxt != '0) && w_ph_nxt;
`else
  logic w_unused_done;
  assign w_unused_done = doneCounting;
  assign w_off         = 1'b0;
`endif

  // Outputs are registered from next-state values so they track the index with no extra lag.
  always_comb begin
    w_dig = w_active_nxt[w_idx_nxt*4 +: 4];
    case (w_idx_nxt)
      2'd3:    w_blank = (w_active_nxt[15:12] == 4'd0);
      2'd2:    w_blank = (w_active_nxt[15:8]  == 8'd0);
      2'd1:    w_blank = (w_active_nxt[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
    w_seg_nxt = bcd_to_seg(w_dig);
    w_an_nxt  = ~(4'b0001 << w_idx_nxt);
    if (w_blank || w_off) begin
      w_seg_nxt = SEG_OFF;
      w_an_nxt  = 4'hF;
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized self-checking bench for seg_display_mux against a cycle-count based reference model.
module tb_seg_display_mux;
  localparam int RD = 4;
  localparam int BH = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * RD;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  seg_display_mux_if ifc ();

  seg_display_mux #(.REFRESH_DIV(RD), .BLINK_HALF(BH), .BLINK_TOGGLES(BT)) dut (
    .Clk100M      (clk),
    .Rst_n        (rst_n),
    .ld           (ifc),
    .doneCounting (done),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: k = clock edges since reset release.
  int          k;
  logic [15:0] m_active, m_shadow;
  logic        m_pend;
  logic        m_bon;
  int          m_bk;

  task automatic model_reset();
    k = 0; m_active = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_bon = 1'b0; m_bk = 0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      k++;
      if (m_pend) begin
        if (k % FRAME == 0) begin m_active = m_shadow; m_pend = 1'b0; end
      end else if (ifc.load_valid) begin
        m_shadow = ifc.load_data; m_pend = 1'b1;
      end
      if (BLINK && done) begin m_bon = 1'b1; m_bk = k; end
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;  4'd3: return 8'hB0;
      4'd4: return 8'h99;  4'd5: return 8'h92;  4'd6: return 8'h82;  4'd7: return 8'hF8;
      4'd8: return 8'h80;  4'd9: return 8'h90;  default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [11:0] expect_out();
    int idx, msnz, j;
    logic [3:0] a;
    if (!rst_n) return {8'hFF, 4'hF};
    idx = (k / RD) % 4;
    msnz = 0;
    for (int i = 0; i < 4; i++) if (m_active[i*4 +: 4] != 4'd0) msnz = i;
    if (m_bon) begin
      j = k - m_bk;
      if (((j / BH) % 2 == 1) && (j / BH < BT)) return {8'hFF, 4'hF};
    end
    if (idx > msnz) return {8'hFF, 4'hF};
    a = 4'hF;
    a[idx] = 1'b0;
    return {pat(m_active[idx*4 +: 4]), a};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++)
      w[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    rst_n = 1'b0; ifc.load_valid = 1'b0; ifc.load_data = 16'h0; done = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e) begin
        n_bad++; $display("FAIL reset_out seg/an=%h/%h required %h/%h", seg, an, e[11:4], e[3:0]);
      end
      n_cmp++;
      if (ifc.load_ready !== 1'b1) begin
        n_bad++; $display("FAIL reset_ready got %b required 1", ifc.load_ready);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [11:0] e;
    int lit;
    lit = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      e = expect_out();
      if (an == 4'hE) lit++;
      n_cmp++;
      if ({seg, an} !== e) begin
        n_bad++; $display("FAIL idle_scan k=%0d seg/an=%h/%h required %h/%h", k, seg, an, e[11:4], e[3:0]);
      end
    end
    n_cmp++;
    if (lit != 3 * RD) begin
      n_bad++; $display("FAIL idle_digit0_duty got %0d lit cycles required %0d", lit, 3 * RD);
    end
  endtask

  // Offer one word at a random point in the frame, then scan a few frames.
  task automatic test_load(input string name, input logic [15:0] w, input int frames);
    logic [11:0] e;
    int to;
    to = 0;
    while (!m_pend && (k % FRAME) < 2 && to < 8) begin tick(); to++; end
    repeat ($urandom_range(0, 5)) tick();
    ifc.load_valid = 1'b1; ifc.load_data = w;
    to = 0;
    while (!ifc.load_ready && to < 4 * FRAME) begin tick(); to++; end
    tick();
    ifc.load_valid = 1'b0;
    for (int c = 0; c < frames * FRAME; c++) begin
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e) begin
        n_bad++; $display("FAIL %s k=%0d seg/an=%h/%h required %h/%h", name, k, seg, an, e[11:4], e[3:0]);
      end
      n_cmp++;
      if (ifc.load_ready !== !m_pend) begin
        n_bad++; $display("FAIL %s_ready k=%0d got %b required %b", name, k, ifc.load_ready, !m_pend);
      end
      tick();
    end
    n_cmp++;
    if (m_active !== w) begin
      n_bad++; $display("FAIL %s_applied model active %h required %h", name, m_active, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    int waited;
    ifc.load_valid = 1'b1; ifc.load_data = 16'h00A0;
    tick();
    ifc.load_data = 16'h0987;
    waited = 0;
    while (!ifc.load_ready && waited < 2 * FRAME) begin
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e) begin
        n_bad++; $display("FAIL b2b_hold k=%0d seg/an=%h/%h required %h/%h", k, seg, an, e[11:4], e[3:0]);
      end
      tick(); waited++;
    end
    n_cmp++;
    if (waited >= 2 * FRAME || k % FRAME != 0) begin
      n_bad++; $display("FAIL b2b_holdoff ready after %0d cycles at k=%0d required at frame boundary", waited, k);
    end
    tick();
    ifc.load_valid = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e || ifc.load_ready !== !m_pend) begin
        n_bad++; $display("FAIL b2b_scan k=%0d seg/an/rdy=%h/%h/%b required %h/%h/%b",
                          k, seg, an, ifc.load_ready, e[11:4], e[3:0], !m_pend);
      end
      tick();
    end
  endtask

  task automatic test_blink();
    logic [11:0] e;
    done = 1'b1; tick(); done = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    done = 1'b1; tick(); done = 1'b0;
    for (int c = 0; c < 2 * BH * BT + 8; c++) begin
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e) begin
        n_bad++; $display("FAIL blink k=%0d seg/an=%h/%h required %h/%h", k, seg, an, e[11:4], e[3:0]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 400; c++) begin
      ifc.load_valid = ($urandom_range(0, 5) == 0);
      ifc.load_data  = rand_word();
      done           = ($urandom_range(0, 40) == 0);
      tick();
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e || ifc.load_ready !== !m_pend) begin
        n_bad++; $display("FAIL random k=%0d seg/an/rdy=%h/%h/%b required %h/%h/%b",
                          k, seg, an, ifc.load_ready, e[11:4], e[3:0], !m_pend);
      end
    end
    ifc.load_valid = 1'b0; done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    int to;
    to = 0;
    while (m_pend && to < 2 * FRAME) begin tick(); to++; end
    ifc.load_valid = 1'b1; ifc.load_data = 16'h0777;
    tick();
    ifc.load_valid = 1'b0; done = 1'b1;
    tick();
    done = 1'b0;
    for (int c = 0; c < BH + 2; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (seg !== 8'hFF || an !== 4'hF || ifc.load_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid seg/an/rdy=%h/%h/%b required ff/f/1", seg, an, ifc.load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      e = expect_out();
      n_cmp++;
      if ({seg, an} !== e || ifc.load_ready !== 1'b1) begin
        n_bad++; $display("FAIL after_reset k=%0d seg/an/rdy=%h/%h/%b required %h/%h/1",
                          k, seg, an, ifc.load_ready, e[11:4], e[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load("load_1234", 16'h1234, 3);
    test_load("load_0050", 16'h0050, 2);
    test_back_to_back();
    test_blink();
    test_random();
    test_load("load_rand", rand_word(), 2);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, Clk100M cycles each digit is lit (>=2).
REQ-002 Parameter BLINK_HALF, default 25000000, Clk100M cycles per blink half-period (>=2).
REQ-003 Parameter BLINK_TOGGLES, default 6, blink half-periods per done event (>=1).
REQ-004 Clk100M  in  1  system clock, rising edge; the only clock.
REQ-005 Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 load_valid  in  1  new digit word offered.
REQ-007 load_data  in  16  four BCD digits; [3:0] = digit0 (rightmost) to [15:12] = digit3.
REQ-008 load_ready  out  1  block accepts load_data this cycle.
REQ-009 doneCounting  in  1  single-cycle pulse from the countdown timer; starts blinking.
REQ-010 seg  out  8  cathodes, active-low; [6:0] = segments a..g, [7] = dp (held 1).
REQ-011 an  out  4  anodes, active-low, one-hot-low when lit.

Function
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1, then wrap; the wrap cycle is the digit tick.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on each tick; index 3->0 is the frame boundary.
REQ-014 seg/an SHALL be registered, reflecting the new index one cycle after the tick.
REQ-015 Transfer occurs when load_valid && load_ready; load_data goes into the shadow register and sets pending.
REQ-016 load_ready SHALL equal !pending.
REQ-017 At a frame boundary with pending set, active <= shadow and pending clears, so active never changes mid-frame.
REQ-018 load_valid at a frame boundary with pending set is not accepted that cycle (load_ready low); it is accepted the next cycle.
REQ-019 BCD 0-9 SHALL decode to standard 7-segment patterns; codes 10-15 SHALL show '-' (g only).
REQ-020 Leading-zero blanking: a digit above the most significant non-zero digit is blanked (an bit high); digit0 is always lit.
REQ-021 Blank digits keep seg = 8'hFF.

Reset
REQ-022 While Rst_n = 0: seg = 8'hFF, an = 4'hF, load_ready = 1, pending = 0, active = 16'h0000, shadow = 0, index = 0, refresh and blink counters = 0.
REQ-023 Reset mid-frame or mid-blink SHALL abandon all state immediately; after release the first tick lights digit0 showing '0'.

Configuration
REQ-024 Macro SEG_BLINK_EN: when defined, doneCounting loads blink_left = BLINK_TOGGLES and a BLINK_HALF timer.
REQ-025 With SEG_BLINK_EN defined, display is forced off (an = 4'hF) during odd half-periods and blinking ends when blink_left reaches 0.
REQ-026 With SEG_BLINK_EN defined, doneCounting during a blink restarts it.
REQ-027 Without SEG_BLINK_EN, doneCounting is ignored and no blink logic is synthesized.

Structure
REQ-028 Package seg_pkg SHALL hold the segment-pattern constants (SEG_OFF = 8'hFF, SEG_DASH), the BCD-to-segment function and the digit-index typedef (2 bits).
REQ-029 Sub-module seg_refresh_tick (parameterized divider producing the one-cycle tick) SHALL be instantiated; all else is in seg_display_mux.

Verification (REFRESH_DIV=4, BLINK_HALF=8, BLINK_TOGGLES=2)
REQ-030 Reset released, no load -> an cycles 4'hE every 16 cycles, other an bits stay high, seg = 0xC0 ('0'); seg/an = FF/F during reset.
REQ-031 Load 16'h1234 mid-frame -> load_ready drops next cycle; frame after next boundary shows 4,3,2,1 on an = E,D,B,7; load_ready returns 1 after the boundary.
REQ-032 Load 16'h0050 -> digits 3 and 2 blanked (an never B or 7 low); digit1 '5' (0x92), digit0 '0' (0xC0).
REQ-033 Load 16'h00A0 -> digit1 shows 0xBF ('-'); second load_valid while pending -> held off until the boundary, then accepted.
REQ-034 With SEG_BLINK_EN, doneCounting pulse -> an = 4'hF for cycles 8-15 after the pulse, normal scan otherwise, blinking finished by cycle 16; repeat pulse at cycle 5 restarts the timing.
REQ-035 Assert Rst_n low during a blink and with pending set -> outputs FF/F immediately; after release load_ready = 1 and display shows '0'.
